// File: rtl/page_load_scheduler.sv
// Schedules SPI page/bootloader loads into a double-buffered page store.
// Holds one pending page and one pending bootloader request; bootloader loads win ties.
module page_load_scheduler (
    input  logic        master_clock,
    input  logic        reset,
    input  logic        bubble_module_enable,
    input  logic        load_page,
    input  logic        load_bootloader,
    input  logic [11:0] bubble_page_input,
    input  logic [2:0]  image_number,
    input  logic        loader_busy,
    input  logic        loader_done,
    output logic        loader_start,
    output logic        loader_bootloader,
    output logic [11:0] loader_page,
    output logic [2:0]  loader_image,
    output logic        write_bank,
    output logic        read_bank,
    output logic        page_ready,
    output logic        overrun,
    output logic        timeout_error
);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StLoading, StSwap} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        page_full_q, page_full_d;
    logic [11:0] page_num_q, page_num_d;
    logic        boot_full_q, boot_full_d;
    logic        boot_q, boot_d;
    logic [11:0] ld_page_q, ld_page_d;
    logic [2:0]  ld_image_q, ld_image_d;
    logic        read_bank_q, read_bank_d;
    logic        page_ready_q, page_ready_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;

    logic        req_page, req_boot;
    logic        page_full_n, boot_full_n;
    logic [11:0] page_num_n;
    logic        issue_go, timeout_hit;

    // Slot contents including this cycle's request, so an idle block issues without a bubble.
    always_comb begin
        req_page    = bubble_module_enable & load_page;
        req_boot    = bubble_module_enable & load_bootloader;
        page_full_n = page_full_q | req_page;
        boot_full_n = boot_full_q | req_boot;
        page_num_n  = req_page ? bubble_page_input : page_num_q;
        issue_go    = (state_q == StIdle) & bubble_module_enable & (page_full_n | boot_full_n);
        timeout_hit = (state_q == StWaitBusy) & ~loader_busy & ~loader_done & (cnt_q == 5'd30);
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle:     if (issue_go) state_d = StIssue;
            StIssue:    state_d = StWaitBusy;
            StWaitBusy: begin
                if (loader_done) begin
                    state_d = bubble_module_enable ? StSwap : StIdle;
                end else if (loader_busy) begin
                    state_d = StLoading;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StLoading:  if (loader_done) state_d = bubble_module_enable ? StSwap : StIdle;
            StSwap:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            page_full_q  <= 1'b0;
            page_num_q   <= '0;
            boot_full_q  <= 1'b0;
            boot_q       <= 1'b0;
            ld_page_q    <= '0;
            ld_image_q   <= '0;
            read_bank_q  <= 1'b0;
            page_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            page_full_q  <= page_full_d;
            page_num_q   <= page_num_d;
            boot_full_q  <= boot_full_d;
            boot_q       <= boot_d;
            ld_page_q    <= ld_page_d;
            ld_image_q   <= ld_image_d;
            read_bank_q  <= read_bank_d;
            page_ready_q <= page_ready_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        page_full_d  = page_full_n;
        page_num_d   = page_num_n;
        boot_full_d  = boot_full_n;
        boot_d       = boot_q;
        ld_page_d    = ld_page_q;
        ld_image_d   = ld_image_q;
        overrun_d    = overrun_q | (req_page & page_full_q);
        timeout_d    = timeout_q | timeout_hit;
        read_bank_d  = read_bank_q ^ (state_d == StSwap);
        page_ready_d = (state_q == StSwap);
        if (!bubble_module_enable) begin
            page_full_d = 1'b0;
            boot_full_d = 1'b0;
        end
        if (issue_go) begin
            ld_image_d = image_number;
            if (boot_full_n) begin
                boot_full_d = 1'b0;
                boot_d      = 1'b1;
                ld_page_d   = '0;
            end else begin
                page_full_d = 1'b0;
                boot_d      = 1'b0;
                ld_page_d   = page_num_n;
            end
        end
    end

    always_comb begin
        loader_start      = (state_q == StIssue);
        loader_bootloader = boot_q;
        loader_page       = ld_page_q;
        loader_image      = ld_image_q;
        read_bank         = read_bank_q;
        write_bank        = ~read_bank_q;
        page_ready        = page_ready_q;
        overrun           = overrun_q;
        timeout_error     = timeout_q;
    end

endmodule

// File: tb/tb_page_load_scheduler.sv
// Directed bench for page_load_scheduler: a vector table plus hand-written corner sequences.
module tb_page_load_scheduler;

    logic        clk = 1'b0;
    logic        rst, en, lp, lb, busy, done;
    logic [11:0] pg;
    logic [2:0]  img;
    logic        start, boot, wb, rb, pr, ov, to;
    logic [11:0] page;
    logic [2:0]  image;

    int checks = 0;
    int errors = 0;

    page_load_scheduler dut (
        .master_clock        (clk),
        .reset               (rst),
        .bubble_module_enable(en),
        .load_page           (lp),
        .load_bootloader     (lb),
        .bubble_page_input   (pg),
        .image_number        (img),
        .loader_busy         (busy),
        .loader_done         (done),
        .loader_start        (start),
        .loader_bootloader   (boot),
        .loader_page         (page),
        .loader_image        (image),
        .write_bank          (wb),
        .read_bank           (rb),
        .page_ready          (pr),
        .overrun             (ov),
        .timeout_error       (to)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, lp, lb, busy, done;
        logic [11:0] pg;
        logic [2:0]  img;
        logic        e_start, e_boot;
        logic [11:0] e_page;
        logic [2:0]  e_img;
        logic        e_rb, e_pr, e_ov, e_to;
    } vec_t;

    function automatic vec_t mk(logic r, logic lpi, logic lbi, logic b, logic d, logic [11:0] p,
                                logic [2:0] im, logic es, logic eb, logic [11:0] ep,
                                logic [2:0] ei, logic erb, logic epr);
        vec_t v;
        v.rst = r; v.en = 1'b1; v.lp = lpi; v.lb = lbi; v.busy = b; v.done = d;
        v.pg = p; v.img = im; v.e_start = es; v.e_boot = eb; v.e_page = ep; v.e_img = ei;
        v.e_rb = erb; v.e_pr = epr; v.e_ov = 1'b0; v.e_to = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; lp = 0; lb = 0; busy = 0; done = 0; pg = '0; img = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        en = 1; rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic count_events(input int n, output int starts, output int readies,
                                output int swaps);
        logic rb0;
        starts = 0; readies = 0; swaps = 0;
        rb0 = rb;
        for (int i = 0; i < n; i++) begin
            tick();
            if (start) starts++;
            if (pr) readies++;
            if (rb !== rb0) swaps++;
        end
    endtask

    vec_t tbl[17];
    int   n_st, n_pr, n_sw, n;

    initial begin
        idle_inputs();
        en = 1;
        // rst lp lb busy done pg img | start boot page img rb pr
        tbl[0]  = mk(0, 1, 0, 0, 0, 12'h123, 3'd5, 1, 0, 12'h123, 3'd5, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 12'h000, 3'd0, 0, 0, 12'h123, 3'd5, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 12'h000, 3'd0, 0, 0, 12'h123, 3'd5, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 12'h000, 3'd0, 0, 0, 12'h123, 3'd5, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 12'h000, 3'd0, 0, 0, 12'h123, 3'd5, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 12'h000, 3'd0, 0, 0, 12'h123, 3'd5, 1, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 12'h000, 3'd0, 0, 0, 12'h123, 3'd5, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 12'h000, 3'd0, 0, 0, 12'h000, 3'd0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 0, 0, 12'h010, 3'd2, 1, 1, 12'h000, 3'd2, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 12'h000, 3'd0, 0, 1, 12'h000, 3'd2, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 12'h000, 3'd0, 0, 1, 12'h000, 3'd2, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 12'h000, 3'd0, 0, 1, 12'h000, 3'd2, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 12'h000, 3'd3, 1, 0, 12'h010, 3'd3, 1, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 12'h000, 3'd0, 0, 0, 12'h010, 3'd3, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 12'h000, 3'd0, 0, 0, 12'h010, 3'd3, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 12'h000, 3'd0, 0, 0, 12'h010, 3'd3, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 12'h000, 3'd0, 0, 0, 12'h010, 3'd3, 0, 0);

        do_reset();
        check("reset_outputs", {start, boot, page, image, rb, wb, pr, ov, to}, 32'b1000);

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; lp = tbl[i].lp; lb = tbl[i].lb;
            busy = tbl[i].busy; done = tbl[i].done; pg = tbl[i].pg; img = tbl[i].img;
            tick();
            check($sformatf("vec%0d", i), {start, boot, page, image, rb, wb, pr, ov, to},
                  {tbl[i].e_start, tbl[i].e_boot, tbl[i].e_page, tbl[i].e_img, tbl[i].e_rb,
                   ~tbl[i].e_rb, tbl[i].e_pr, tbl[i].e_ov, tbl[i].e_to});
        end
        idle_inputs();

        // Long load: busy at cycle 2, done at cycle 100.
        do_reset();
        lp = 1; pg = 12'h123; img = 3'd5;
        tick();
        check("long_issue", {start, page, image}, {1'b1, 12'h123, 3'd5});
        idle_inputs();
        tick();
        busy = 1;
        tick();
        busy = 0;
        repeat (97) tick();
        done = 1;
        tick();
        done = 0;
        check("long_swap", {rb, pr}, 2'b10);
        tick();
        check("long_ready", {rb, pr}, 2'b11);

        // Page overwritten while loading.
        do_reset();
        lp = 1; pg = 12'h050;
        tick();
        idle_inputs();
        tick();
        busy = 1;
        tick();
        busy = 0; lp = 1; pg = 12'h020;
        tick();
        check("no_overrun_first", ov, 0);
        pg = 12'h021;
        tick();
        idle_inputs();
        check("overrun_set", {ov, page}, {1'b1, 12'h050});
        done = 1;
        tick();
        done = 0;
        tick();
        tick();
        check("overrun_reissue", {start, boot, page}, {1'b1, 1'b0, 12'h021});
        tick();
        busy = 1;
        tick();
        busy = 0; done = 1;
        tick();
        done = 0;
        count_events(12, n_st, n_pr, n_sw);
        check("overrun_one_more_load", n_st, 0);
        check("overrun_sticky", ov, 1);

        // Duplicate bootloader request while pending is absorbed.
        do_reset();
        lp = 1; pg = 12'h0F0;
        tick();
        idle_inputs();
        tick();
        busy = 1;
        tick();
        busy = 0; lb = 1;
        tick();
        tick();
        lb = 0;
        check("dup_boot_no_overrun", ov, 0);
        done = 1;
        tick();
        done = 0;
        count_events(6, n_st, n_pr, n_sw);
        check("dup_boot_single_issue", {n_st, boot}, {32'd1, 1'b1});

        // Timeout with busy and done held low.
        do_reset();
        lp = 1; pg = 12'h0AA; img = 3'd1;
        tick();
        idle_inputs();
        check("to_issue", start, 1);
        tick();
        n = 0;
        while (!to && n < 40) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 31);
        count_events(4, n_st, n_pr, n_sw);
        check("timeout_idle", {n_st, n_sw, rb, to}, {32'd0, 32'd0, 1'b0, 1'b1});

        // Enable drops during a load with a page request pending.
        do_reset();
        lp = 1; pg = 12'h033;
        tick();
        idle_inputs();
        tick();
        busy = 1;
        tick();
        busy = 0; lp = 1; pg = 12'h077;
        tick();
        idle_inputs();
        en = 0;
        tick();
        done = 1;
        tick();
        done = 0;
        check("disable_no_swap", {rb, pr}, 2'b00);
        count_events(10, n_st, n_pr, n_sw);
        check("disable_quiet", {n_st, n_pr, n_sw}, {32'd0, 32'd0, 32'd0});
        en = 1;
        count_events(10, n_st, n_pr, n_sw);
        check("disable_discarded", n_st, 0);

        // Reset in the middle of a load; a late done is ignored.
        do_reset();
        lp = 1; pg = 12'h044; img = 3'd6;
        tick();
        idle_inputs();
        tick();
        busy = 1;
        tick();
        busy = 0; rst = 1;
        tick();
        rst = 0;
        check("midreset_outputs", {start, boot, page, image, rb, wb, pr, ov, to}, 32'b1000);
        done = 1;
        tick();
        done = 0;
        count_events(6, n_st, n_pr, n_sw);
        check("midreset_no_swap", {n_st, n_pr, n_sw, rb}, {32'd0, 32'd0, 32'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
